// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the fetch -> queue -> decode path: default widths,
// the (pc, inst) entry type and a small pair-count helper.
package inst_fetch_queue_pkg;

  localparam int unsigned IFQ_ADDR_W = 32;
  localparam int unsigned IFQ_INST_W = 32;
  localparam int unsigned IFQ_DEPTH  = 8;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_INST_W-1:0] inst;
  } fetch_entry_t;

  // Slot 2 only counts when slot 1 is also active.
  function automatic logic [1:0] pair_count(input logic first, input logic second);
    return {1'b0, first} + {1'b0, first & second};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode-side bundle of the instruction fetch queue.
// master = fetch + decode environment, slave = the queue.
interface inst_fetch_queue_if
  import inst_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = IFQ_ADDR_W,
  parameter int INST_W = IFQ_INST_W,
  parameter int DEPTH  = IFQ_DEPTH
);
  logic                     flush;
  logic                     push_valid_1;
  logic                     push_valid_2;
  logic [ADDR_W-1:0]        pc_i_1;
  logic [ADDR_W-1:0]        pc_i_2;
  logic [INST_W-1:0]        inst_i_1;
  logic [INST_W-1:0]        inst_i_2;
  logic                     pop_ready_1;
  logic                     pop_ready_2;
  logic                     inst_valid_o_1;
  logic                     inst_valid_o_2;
  logic [ADDR_W-1:0]        pc_o_1;
  logic [ADDR_W-1:0]        pc_o_2;
  logic [INST_W-1:0]        inst_o_1;
  logic [INST_W-1:0]        inst_o_2;
  logic                     pause_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport master (
    output flush, push_valid_1, push_valid_2, pc_i_1, pc_i_2, inst_i_1, inst_i_2,
           pop_ready_1, pop_ready_2,
    input  inst_valid_o_1, inst_valid_o_2, pc_o_1, pc_o_2, inst_o_1, inst_o_2,
           pause_o, count_o
  );

  modport slave (
    input  flush, push_valid_1, push_valid_2, pc_i_1, pc_i_2, inst_i_1, inst_i_2,
           pop_ready_1, pop_ready_2,
    output inst_valid_o_1, inst_valid_o_2, pc_o_1, pc_o_2, inst_o_1, inst_o_2,
           pause_o, count_o
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH-entry register array with two write ports and two read ports.
// Storage is deliberately not reset; the queue masks reads with its valids.
module fetch_queue_mem #(
  parameter int DEPTH = 8,
  parameter int DW    = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_1_i,
  input  logic [AW-1:0] wa_1_i,
  input  logic [DW-1:0] wd_1_i,
  input  logic          we_2_i,
  input  logic [AW-1:0] wa_2_i,
  input  logic [DW-1:0] wd_2_i,
  input  logic [AW-1:0] ra_1_i,
  input  logic [AW-1:0] ra_2_i,
  output logic [DW-1:0] rd_1_o,
  output logic [DW-1:0] rd_2_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Both write addresses are consecutive slots, so they never collide.
  always_ff @(posedge clk) begin
    if (we_1_i) mem_q[wa_1_i] <= wd_1_i;
    if (we_2_i) mem_q[wa_2_i] <= wd_2_i;
  end

  assign rd_1_o = mem_q[ra_1_i];
  assign rd_2_o = mem_q[ra_2_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-slot in-order instruction queue between fetch and decode, with a
// pause back to the PC stage and a redirect flush.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int ADDR_W = IFQ_ADDR_W,
  parameter int INST_W = IFQ_INST_W
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_queue_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = ADDR_W + INST_W;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          valid_1_s, valid_2_s, pause_s;
  logic          we_1_s, we_2_s;
  logic [1:0]    n_pop_s, n_push_s;
  logic [PW-1:0] head_nx_s, tail_nx_s;
  logic [DW-1:0] rd_1_s, rd_2_s;

  assign valid_1_s = (count_q != CW'(0));
  assign valid_2_s = (count_q >= CW'(2));
  // Pause looks at the current count only, so a pop frees space one cycle later.
  assign pause_s   = (count_q > CW'(DEPTH - 2));

  assign n_pop_s   = pair_count(valid_1_s & bus.pop_ready_1, valid_2_s & bus.pop_ready_2);
  assign we_1_s    = bus.push_valid_1 & ~pause_s & ~bus.flush;
  assign we_2_s    = we_1_s & bus.push_valid_2;
  assign n_push_s  = pair_count(we_1_s, bus.push_valid_2);

  assign head_nx_s = head_q + PW'(1);
  assign tail_nx_s = tail_q + PW'(1);

  // Next-state pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(n_pop_s);
      tail_d  = tail_q + PW'(n_push_s);
      count_d = count_q + CW'(n_push_s) - CW'(n_pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk    (clk),
    .we_1_i (we_1_s),
    .wa_1_i (tail_q),
    .wd_1_i ({bus.pc_i_1, bus.inst_i_1}),
    .we_2_i (we_2_s),
    .wa_2_i (tail_nx_s),
    .wd_2_i ({bus.pc_i_2, bus.inst_i_2}),
    .ra_1_i (head_q),
    .ra_2_i (head_nx_s),
    .rd_1_o (rd_1_s),
    .rd_2_o (rd_2_s)
  );

  assign bus.inst_valid_o_1 = valid_1_s;
  assign bus.inst_valid_o_2 = valid_2_s;
  assign bus.pc_o_1   = valid_1_s ? rd_1_s[DW-1:INST_W] : {ADDR_W{1'b0}};
  assign bus.inst_o_1 = valid_1_s ? rd_1_s[INST_W-1:0]  : {INST_W{1'b0}};
  assign bus.pc_o_2   = valid_2_s ? rd_2_s[DW-1:INST_W] : {ADDR_W{1'b0}};
  assign bus.inst_o_2 = valid_2_s ? rd_2_s[INST_W-1:0]  : {INST_W{1'b0}};
  assign bus.pause_o  = pause_s;
  assign bus.count_o  = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: the driver queues expected entries
// as it issues pushes; a negedge monitor checks head outputs and retires pops.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int IW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH)) bus();

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .INST_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_entry_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc_npush = 0;
  logic cyc_flush = 1'b0;
  logic mon_en    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record which pushes the queue must accept.
  task automatic cyc(input logic pv1, input logic pv2,
                     input logic [31:0] pc1, input logic [31:0] in1,
                     input logic [31:0] pc2, input logic [31:0] in2,
                     input logic r1, input logic r2, input logic fl);
    fetch_entry_t e;
    @(posedge clk);
    #2;
    bus.flush        = fl;
    bus.push_valid_1 = pv1;
    bus.push_valid_2 = pv2;
    bus.pc_i_1       = pc1;
    bus.inst_i_1     = in1;
    bus.pc_i_2       = pc2;
    bus.inst_i_2     = in2;
    bus.pop_ready_1  = r1;
    bus.pop_ready_2  = r2;
    cyc_flush        = fl;
    cyc_npush        = 0;
    if (!fl && exp_q.size() <= DEPTH - 2 && pv1) begin
      e.pc = pc1; e.inst = in1;
      exp_q.push_back(e);
      cyc_npush = 1;
      if (pv2) begin
        e.pc = pc2; e.inst = in2;
        exp_q.push_back(e);
        cyc_npush = 2;
      end
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push2(input logic [31:0] pc1, input logic [31:0] pc2,
                       input logic r1, input logic r2);
    cyc(1'b1, 1'b1, pc1, 32'hA000_0000 | pc1, pc2, 32'hA000_0000 | pc2, r1, r2, 1'b0);
  endtask

  task automatic push1(input logic [31:0] pc1);
    cyc(1'b1, 1'b0, pc1, 32'hA000_0000 | pc1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input logic r1, input logic r2);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, r1, r2, 1'b0);
  endtask

  // Monitor: compare the presented head entries, then retire this cycle's pops.
  always @(negedge clk) begin
    if (mon_en) begin
      int base;
      base = exp_q.size() - cyc_npush;
      chk("mon_count", 64'(bus.count_o), 64'(base));
      chk("mon_valid_1", 64'(bus.inst_valid_o_1), 64'(base >= 1));
      chk("mon_valid_2", 64'(bus.inst_valid_o_2), 64'(base >= 2));
      chk("mon_pause", 64'(bus.pause_o), 64'(base > DEPTH - 2));
      if (base >= 1) begin
        chk("mon_pc_1", 64'(bus.pc_o_1), 64'(exp_q[0].pc));
        chk("mon_inst_1", 64'(bus.inst_o_1), 64'(exp_q[0].inst));
      end else begin
        chk("mon_pc_1_zero", 64'(bus.pc_o_1), 64'h0);
      end
      if (base >= 2) begin
        chk("mon_pc_2", 64'(bus.pc_o_2), 64'(exp_q[1].pc));
        chk("mon_inst_2", 64'(bus.inst_o_2), 64'(exp_q[1].inst));
      end else begin
        chk("mon_pc_2_zero", 64'(bus.pc_o_2), 64'h0);
      end
      if (cyc_flush) begin
        exp_q.delete();
      end else if (base >= 1 && bus.pop_ready_1) begin
        void'(exp_q.pop_front());
        if (base >= 2 && bus.pop_ready_2) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.flush = 1'b0; bus.push_valid_1 = 1'b0; bus.push_valid_2 = 1'b0;
    bus.pc_i_1 = 32'h0; bus.pc_i_2 = 32'h0; bus.inst_i_1 = 32'h0; bus.inst_i_2 = 32'h0;
    bus.pop_ready_1 = 1'b0; bus.pop_ready_2 = 1'b0;
    #1;
    chk("rst_count", 64'(bus.count_o), 64'h0);
    chk("rst_valid_1", 64'(bus.inst_valid_o_1), 64'h0);
    chk("rst_valid_2", 64'(bus.inst_valid_o_2), 64'h0);
    chk("rst_pc_1", 64'(bus.pc_o_1), 64'h0);
    chk("rst_pause", 64'(bus.pause_o), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // First pair visible the next cycle.
    cyc(1'b1, 1'b1, 32'h0, 32'h1111_1111, 32'h4, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    idle();
    chk("pair_count", 64'(bus.count_o), 64'd2);
    chk("pair_pc_1", 64'(bus.pc_o_1), 64'h0);
    chk("pair_pc_2", 64'(bus.pc_o_2), 64'h4);
    chk("pair_inst_1", 64'(bus.inst_o_1), 64'h1111_1111);
    chk("pair_inst_2", 64'(bus.inst_o_2), 64'h2222_2222);

    // Fill to DEPTH; further pushes are ignored while paused.
    push2(32'h8, 32'hC, 1'b0, 1'b0);
    push2(32'h10, 32'h14, 1'b0, 1'b0);
    push2(32'h18, 32'h1C, 1'b0, 1'b0);
    idle();
    chk("full_count", 64'(bus.count_o), 64'd8);
    chk("full_pause", 64'(bus.pause_o), 64'd1);
    push2(32'h100, 32'h104, 1'b0, 1'b0);
    idle();
    chk("full_ignore_count", 64'(bus.count_o), 64'd8);

    // Pop two while paused: push still dropped, pause clears a cycle later.
    push2(32'h100, 32'h104, 1'b1, 1'b1);
    idle();
    chk("lag_count", 64'(bus.count_o), 64'd6);
    chk("lag_pause", 64'(bus.pause_o), 64'd0);
    chk("lag_pc_1", 64'(bus.pc_o_1), 64'h8);

    pop(1'b1, 1'b1);
    pop(1'b1, 1'b0);
    idle();
    chk("three_count", 64'(bus.count_o), 64'd3);
    chk("three_pc_1", 64'(bus.pc_o_1), 64'h14);

    // Push pair + pop two in one cycle; head+1 read wraps from slot 7 to 0.
    push2(32'h200, 32'h204, 1'b1, 1'b1);
    idle();
    chk("wrap_count", 64'(bus.count_o), 64'd3);
    chk("wrap_pc_1", 64'(bus.pc_o_1), 64'h1C);
    chk("wrap_pc_2", 64'(bus.pc_o_2), 64'h200);
    pop(1'b1, 1'b1);
    idle();
    chk("wrap_pop_count", 64'(bus.count_o), 64'd1);
    chk("wrap_pop_pc_1", 64'(bus.pc_o_1), 64'h204);
    chk("wrap_pop_valid_2", 64'(bus.inst_valid_o_2), 64'd0);

    // Slot 2 alone carries nothing.
    cyc(1'b0, 1'b1, 32'h0, 32'h0, 32'h300, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    idle();
    chk("slot2_only_count", 64'(bus.count_o), 64'd1);

    push1(32'h300);
    pop(1'b0, 1'b1);
    idle();
    chk("ready2_only_count", 64'(bus.count_o), 64'd2);
    chk("ready2_only_pc_1", 64'(bus.pc_o_1), 64'h204);
    pop(1'b1, 1'b0);
    pop(1'b1, 1'b1);
    idle();
    chk("single_pop_count", 64'(bus.count_o), 64'd0);
    chk("single_pop_valid_1", 64'(bus.inst_valid_o_1), 64'd0);
    pop(1'b1, 1'b1);
    idle();
    chk("empty_pop_count", 64'(bus.count_o), 64'd0);

    // Flush at count 5 with a same-cycle push.
    push2(32'h400, 32'h404, 1'b0, 1'b0);
    push2(32'h408, 32'h40C, 1'b0, 1'b0);
    push1(32'h410);
    idle();
    chk("preflush_count", 64'(bus.count_o), 64'd5);
    cyc(1'b1, 1'b1, 32'h500, 32'h5, 32'h504, 32'h6, 1'b1, 1'b0, 1'b1);
    idle();
    chk("flush_count", 64'(bus.count_o), 64'd0);
    chk("flush_valid_1", 64'(bus.inst_valid_o_1), 64'd0);
    chk("flush_valid_2", 64'(bus.inst_valid_o_2), 64'd0);
    chk("flush_pause", 64'(bus.pause_o), 64'd0);
    push1(32'h1C);
    idle();
    chk("postflush_pc_1", 64'(bus.pc_o_1), 64'h1C);
    chk("postflush_count", 64'(bus.count_o), 64'd1);

    // Asynchronous reset in the middle of a cycle.
    push2(32'h600, 32'h604, 1'b0, 1'b0);
    idle();
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 64'(bus.count_o), 64'd0);
    chk("async_rst_valid_1", 64'(bus.inst_valid_o_1), 64'd0);
    chk("async_rst_pc_1", 64'(bus.pc_o_1), 64'h0);
    exp_q.delete();
    cyc_npush = 0;
    cyc_flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
